// File: rtl/tx_pcs_pkg.sv
// rtl/tx_pcs_pkg.sv - shared constants and lane helpers for the TX PCS lane path
// Purpose: coded-block widths, maximum lane count, lane-index width and
//          MSB-first lane slice helpers shared by the lane distributor files.
// Ports:   none (package).
package tx_pcs_pkg;

  localparam int NB_DATA_CODED  = 66;
  localparam int NB_DATA_TAGGED = NB_DATA_CODED + 1;
  localparam int MAX_LANES      = 20;

  // Width of an index that addresses lanes 0..n_lanes-1.
  function automatic int lane_idx_width(input int n_lanes);
    return (n_lanes <= 1) ? 1 : $clog2(n_lanes);
  endfunction

  // LSB position of a lane inside a lane bus; lane 0 occupies the MSBs.
  function automatic int lane_lsb(input int lane, input int n_lanes, input int nb);
    return (n_lanes - 1 - lane) * nb;
  endfunction

endpackage

// File: rtl/lane_align_tracker.sv
// rtl/lane_align_tracker.sv - aligner-tag run tracking, realign pulse/count and lock
// Purpose: detects the start of a tagged run, flags a realign when it lands
//          mid-group, keeps a saturating realign count and the lock flag.
// Ports:
//   i_clock, i_reset        clock, asynchronous active-low reset
//   i_enable                freeze when low (pulse forced low)
//   i_accept, i_tag         accepted block strobe and its tag
//   i_at_boundary           write index is at slot 0
//   i_group_done            a group completes on this accept
//   i_group_all/i_group_any all / any active tags of that group set
//   o_realign_now           combinational realign decision for this accept
//   o_realign               registered one-cycle realign pulse
//   o_realign_count         saturating realign count
//   o_lock                  tag groups aligned to lane 0
module lane_align_tracker
  import tx_pcs_pkg::*;
#(
  parameter int NB_ERR_CNT = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_accept,
  input  logic                  i_tag,
  input  logic                  i_at_boundary,
  input  logic                  i_group_done,
  input  logic                  i_group_all,
  input  logic                  i_group_any,
  output logic                  o_realign_now,
  output logic                  o_realign,
  output logic [NB_ERR_CNT-1:0] o_realign_count,
  output logic                  o_lock
);

  logic prev_tag;

  // A run starting at slot 0 is already aligned; only mid-group starts realign.
  assign o_realign_now = i_accept & i_tag & ~prev_tag & ~i_at_boundary;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      prev_tag        <= 1'b0;
      o_realign       <= 1'b0;
      o_realign_count <= '0;
      o_lock          <= 1'b0;
    end else if (!i_enable) begin
      o_realign <= 1'b0;
    end else begin
      o_realign <= o_realign_now;
      if (i_accept) prev_tag <= i_tag;
      if (o_realign_now) begin
        if (o_realign_count != '1) o_realign_count <= o_realign_count + NB_ERR_CNT'(1);
        o_lock <= 1'b0;
      end else if (i_group_done) begin
        // An all-untagged group leaves lock unchanged; mixed tags drop it.
        if (i_group_all)      o_lock <= 1'b1;
        else if (i_group_any) o_lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tx_lane_distributor.sv
// rtl/tx_lane_distributor.sv - gathers tagged 66b blocks into an N-lane bus
// Purpose: collects coded blocks into a shadow buffer, publishes a full group
//          on the lane bus with a one-cycle o_valid, supports a run-time
//          active lane count and realigns groups on aligner-tag run starts.
// Ports:
//   i_clock, i_reset     clock, asynchronous active-low reset
//   i_enable             freeze all state when low
//   i_valid, i_data      input block strobe and coded block
//   i_tag                aligner tag of the block
//   i_rf_active_lanes    requested active lane count (0 / too large -> N_LANES)
//   o_data, o_tag_bus    lane bus and per-lane tags, lane 0 in MSBs
//   o_valid              one-cycle pulse per completed group
//   o_lock               tag groups aligned to lane 0
//   o_realign            one-cycle pulse on realign
//   o_realign_count      saturating realign count
module tx_lane_distributor
  import tx_pcs_pkg::*;
#(
  parameter int NB_DATA_CODED = 66,
  parameter int N_LANES       = MAX_LANES,
  parameter int NB_ERR_CNT    = 8
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_enable,
  input  logic                             i_valid,
  input  logic [NB_DATA_CODED-1:0]         i_data,
  input  logic                             i_tag,
  input  logic [$clog2(N_LANES):0]         i_rf_active_lanes,
  output logic [NB_DATA_CODED*N_LANES-1:0] o_data,
  output logic [N_LANES-1:0]               o_tag_bus,
  output logic                             o_valid,
  output logic                             o_lock,
  output logic                             o_realign,
  output logic [NB_ERR_CNT-1:0]            o_realign_count
);

  localparam int NB_IDX = lane_idx_width(N_LANES);
  localparam int NB_ACT = $clog2(N_LANES) + 1;
  localparam logic [NB_ACT-1:0] ACT_MAX = NB_ACT'(N_LANES);

  logic [NB_DATA_CODED-1:0]         shadow [N_LANES];
  logic [N_LANES-1:0]               tag_sh;   // indexed by lane number
  logic [NB_IDX-1:0]                wr_idx;
  logic [NB_ACT-1:0]                act_q, act_req, act_eff;
  logic [NB_DATA_CODED*N_LANES-1:0] grp_data;
  logic [N_LANES-1:0]               grp_tags;
  logic                             grp_all, grp_any;
  logic                             accept, at_boundary, last_slot, grp_done, realign_now;

  assign accept      = i_enable & i_valid;
  assign at_boundary = (wr_idx == '0);
  assign last_slot   = (NB_ACT'(wr_idx) == act_eff - NB_ACT'(1));
  // A realign always restarts at slot 0, so it never completes a group.
  assign grp_done    = accept & last_slot & ~realign_now;

  // The lane count is taken live at slot 0 and held for the rest of the group.
  always_comb begin
    act_req = i_rf_active_lanes;
    if (i_rf_active_lanes == '0 || i_rf_active_lanes > ACT_MAX) act_req = ACT_MAX;
    act_eff = at_boundary ? act_req : act_q;
  end

  // Completed group image: shadow slots plus the block arriving now in the
  // last slot; lanes beyond the active count are zero.
  always_comb begin
    grp_data = '0;
    grp_tags = '0;
    grp_all  = 1'b1;
    grp_any  = 1'b0;
    for (int l = 0; l < N_LANES; l++) begin
      if (NB_ACT'(l) < act_eff) begin
        grp_data[lane_lsb(l, N_LANES, NB_DATA_CODED) +: NB_DATA_CODED] =
          (NB_IDX'(l) == wr_idx) ? i_data : shadow[l];
        grp_tags[N_LANES-1-l] = (NB_IDX'(l) == wr_idx) ? i_tag : tag_sh[l];
        grp_all = grp_all & grp_tags[N_LANES-1-l];
        grp_any = grp_any | grp_tags[N_LANES-1-l];
      end
    end
  end

  lane_align_tracker #(
    .NB_ERR_CNT (NB_ERR_CNT)
  ) u_tracker (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_accept        (accept),
    .i_tag           (i_tag),
    .i_at_boundary   (at_boundary),
    .i_group_done    (grp_done),
    .i_group_all     (grp_all),
    .i_group_any     (grp_any),
    .o_realign_now   (realign_now),
    .o_realign       (o_realign),
    .o_realign_count (o_realign_count),
    .o_lock          (o_lock)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int l = 0; l < N_LANES; l++) shadow[l] <= '0;
      tag_sh    <= '0;
      wr_idx    <= '0;
      act_q     <= ACT_MAX;
      o_data    <= '0;
      o_tag_bus <= '0;
      o_valid   <= 1'b0;
    end else if (!i_enable) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= grp_done;
      if (accept) begin
        if (realign_now) begin
          // Drop the partial group; the tagged block opens a new one.
          shadow[0] <= i_data;
          tag_sh[0] <= i_tag;
          wr_idx    <= NB_IDX'(1);
        end else begin
          shadow[wr_idx] <= i_data;
          tag_sh[wr_idx] <= i_tag;
          if (at_boundary) act_q <= act_req;
          if (grp_done) begin
            wr_idx    <= '0;
            o_data    <= grp_data;
            o_tag_bus <= grp_tags;
          end else begin
            wr_idx <= wr_idx + NB_IDX'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_lane_distributor.sv
// tb/tb_tx_lane_distributor.sv - self-checking bench for tx_lane_distributor
module tb_tx_lane_distributor;

  localparam int NB = 66;
  localparam int NL = 20;
  localparam int NE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_enable = 1'b0;
  logic            i_valid = 1'b0;
  logic [NB-1:0]   i_data = '0;
  logic            i_tag = 1'b0;
  logic [5:0]      i_rf_active_lanes = 6'd20;
  logic [NB*NL-1:0] o_data;
  logic [NL-1:0]   o_tag_bus;
  logic            o_valid, o_lock, o_realign;
  logic [NE-1:0]   o_realign_count;

  int n_checks = 0;
  int n_fail = 0;

  tx_lane_distributor #(.NB_DATA_CODED(NB), .N_LANES(NL), .NB_ERR_CNT(NE)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(i_enable), .i_valid(i_valid),
    .i_data(i_data), .i_tag(i_tag), .i_rf_active_lanes(i_rf_active_lanes),
    .o_data(o_data), .o_tag_bus(o_tag_bus), .o_valid(o_valid), .o_lock(o_lock),
    .o_realign(o_realign), .o_realign_count(o_realign_count)
  );

  always #5 clk = ~clk;

  // Reference model: the open group is a queue of accepted blocks.
  logic [NB-1:0]    q_data[$];
  bit               q_tag[$];
  int               m_act, m_cnt;
  bit               m_prev, m_lock, m_valid, m_realign;
  logic [NB*NL-1:0] m_data;
  logic [NL-1:0]    m_tags;

  task automatic model_reset();
    q_data.delete(); q_tag.delete();
    m_act = NL; m_cnt = 0; m_prev = 0; m_lock = 0; m_valid = 0; m_realign = 0;
    m_data = '0; m_tags = '0;
  endtask

  task automatic model_step(input bit en, input bit v, input bit t, input logic [NB-1:0] d, input int act);
    int ones;
    m_valid = 0; m_realign = 0;
    if (en && v) begin
      if (t && !m_prev && q_data.size() != 0) begin
        q_data.delete(); q_tag.delete();
        q_data.push_back(d); q_tag.push_back(t);
        m_realign = 1; m_lock = 0;
        if (m_cnt < 255) m_cnt++;
      end else begin
        if (q_data.size() == 0) m_act = (act == 0 || act > NL) ? NL : act;
        q_data.push_back(d); q_tag.push_back(t);
        if (q_data.size() == m_act) begin
          m_valid = 1; m_data = '0; m_tags = '0; ones = 0;
          for (int l = 0; l < NL; l++) begin
            m_data = (m_data << NB) | ((l < m_act) ? q_data[l] : '0);
            m_tags = (m_tags << 1) | ((l < m_act) ? NL'(q_tag[l]) : '0);
            if (l < m_act && q_tag[l]) ones++;
          end
          if (ones == m_act) m_lock = 1;
          else if (ones != 0) m_lock = 0;
          q_data.delete(); q_tag.delete();
        end
      end
      m_prev = t;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [NB*NL-1:0] exp);
    logic [NB*NL-1:0] got;
    bit shown;
    got = o_data; shown = 0;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      for (int l = 0; l < NL; l++)
        if (!shown && got[(NL-1-l)*NB +: NB] !== exp[(NL-1-l)*NB +: NB]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, l, got[(NL-1-l)*NB +: NB], exp[(NL-1-l)*NB +: NB]);
          shown = 1;
        end
      if (!shown) $display("FAIL %s: data bus differs", name);
    end
  endtask

  task automatic step(input bit en, input bit v, input bit t, input logic [NB-1:0] d, input int act);
    i_enable = en; i_valid = v; i_tag = t; i_data = d; i_rf_active_lanes = 6'(act);
    @(posedge clk); #1;
    model_step(en, v, t, d, act);
    check("o_valid", 64'(o_valid), 64'(m_valid));
    check("o_realign", 64'(o_realign), 64'(m_realign));
    check("o_lock", 64'(o_lock), 64'(m_lock));
    check("o_realign_count", 64'(o_realign_count), 64'(m_cnt));
    check("o_tag_bus", 64'(o_tag_bus), 64'(m_tags));
    check_data("o_data", m_data);
  endtask

  task automatic do_reset();
    i_valid = 0; i_enable = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst o_valid", 64'(o_valid), 64'd0);
    check("rst o_realign", 64'(o_realign), 64'd0);
    check("rst o_lock", 64'(o_lock), 64'd0);
    check("rst o_realign_count", 64'(o_realign_count), 64'd0);
    check("rst o_tag_bus", 64'(o_tag_bus), 64'd0);
    check_data("rst o_data", '0);
    model_reset();
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; bit t; logic [NB-1:0] d;
    bit ev; bit er; bit el; int ec;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input bit v, input bit t, input int d, input bit ev, input bit er, input bit el, input int ec);
    vec_t r;
    r.v = v; r.t = t; r.d = NB'(d); r.ev = ev; r.er = er; r.el = el; r.ec = ec;
    tbl.push_back(r);
  endtask

  int act_choices[6] = '{4, 20, 0, 25, 2, 7};

  initial begin
    model_reset();
    #3;
    check("init o_valid", 64'(o_valid), 64'd0);
    check("init o_tag_bus", 64'(o_tag_bus), 64'd0);
    check_data("init o_data", '0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Table: active=4 groups, realign mid-group, lock set, idle cycle, mixed tags.
    add_vec(1,0,200, 0,0,0,0); add_vec(1,0,201, 0,0,0,0);
    add_vec(1,0,202, 0,0,0,0); add_vec(1,0,203, 1,0,0,0);
    add_vec(1,0,204, 0,0,0,0); add_vec(1,0,205, 0,0,0,0);
    add_vec(1,1,206, 0,1,0,1); add_vec(1,1,207, 0,0,0,1);
    add_vec(1,1,208, 0,0,0,1); add_vec(1,1,209, 1,0,1,1);
    add_vec(1,1,210, 0,0,1,1); add_vec(0,0,999, 0,0,1,1);
    add_vec(1,1,211, 0,0,1,1); add_vec(1,0,212, 0,0,1,1);
    add_vec(1,0,213, 1,0,0,1);
    foreach (tbl[i]) begin
      step(1, tbl[i].v, tbl[i].t, tbl[i].d, 4);
      check($sformatf("tbl[%0d] valid", i), 64'(o_valid), 64'(tbl[i].ev));
      check($sformatf("tbl[%0d] realign", i), 64'(o_realign), 64'(tbl[i].er));
      check($sformatf("tbl[%0d] lock", i), 64'(o_lock), 64'(tbl[i].el));
      check($sformatf("tbl[%0d] count", i), 64'(o_realign_count), 64'(tbl[i].ec));
    end
    check("tbl lane4 zero", 64'(o_data[(NL-1-4)*NB +: NB]), 64'd0);
    check("tbl lane2 data", 64'(o_data[(NL-1-2)*NB +: NB]), 64'd212);

    // 20 consecutive untagged blocks, data = k.
    do_reset();
    for (int k = 0; k < NL; k++) step(1, 1, 0, NB'(k), 20);
    check("full o_valid", 64'(o_valid), 64'd1);
    for (int k = 0; k < NL; k++)
      check($sformatf("full lane%0d", k), 64'(o_data[(NL-1-k)*NB +: NB]), 64'(k));

    // Same with i_valid every 3rd cycle.
    for (int i = 0; i < 3*NL; i++) step(1, (i % 3) == 2, 0, NB'(i / 3), 20);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 20);

    // 7 untagged, then 20 tagged blocks.
    for (int i = 0; i < 7; i++) step(1, 1, 0, NB'(500 + i), 20);
    for (int i = 0; i < 20; i++) step(1, 1, 1, NB'(600 + i), 20);
    check("tagged tag_bus", 64'(o_tag_bus), 64'hFFFFF);
    check("tagged lock", 64'(o_lock), 64'd1);
    check("tagged count", 64'(o_realign_count), 64'd1);

    // Active count changed mid-group, then a full 20-lane group.
    for (int i = 0; i < 2; i++) step(1, 1, 0, NB'(700 + i), 4);
    for (int i = 0; i < 2; i++) step(1, 1, 0, NB'(702 + i), 20);
    for (int i = 0; i < 20; i++) step(1, 1, 0, NB'(800 + i), 20);

    // Reset mid-group, then a fresh group.
    for (int i = 0; i < 10; i++) step(1, 1, 0, NB'(900 + i), 20);
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 0, NB'(1000 + i), 20);

    // Enable low mid-group while blocks are offered.
    for (int i = 0; i < 5; i++) step(1, 1, 0, NB'(1100 + i), 20);
    for (int i = 0; i < 5; i++) step(0, 1, 1, NB'(1200 + i), 20);
    for (int i = 5; i < 20; i++) step(1, 1, 0, NB'(1100 + i), 20);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
           {2'($urandom), $urandom, $urandom}, act_choices[$urandom_range(0, 5)]);

    // Counter saturation with 300 misaligned runs.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, NB'(i), 20);
      step(1, 1, 1, NB'(i), 20);
    end
    check("sat count", 64'(o_realign_count), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
